// File: rtl/im_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: state encodings and
// the default bit period.
package im_uart_loader_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    S_COUNT,
    S_LOAD,
    S_DONE,
    S_ERR
  } ld_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

endpackage

// File: rtl/im_uart_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start
// detection, one-cycle rx_valid or rx_err pulse decided by the stop bit.
module uart_rx_byte
  import im_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= R_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= Rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        // A falling edge is required, so a line held low after a bad stop never re-arms.
        if (prev_q && !sync2_q) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = R_IDLE;
          end else begin
            state_d = R_DATA;
            bit_d   = '0;
          end
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (sync2_q) valid_d = 1'b1;
          else         err_d   = 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_data  = shift_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/im_uart_loader.sv
// Boot loader: frames UART bytes (count byte + big-endian words) into IM writes and
// holds the CPU until the whole image has been written.
module im_uart_loader
  import im_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Rxd,
  output logic              ImWe,
  output logic [ADDR_W-1:0] ImWAdr,
  output logic [31:0]       ImWData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Err
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

  logic       rx_valid, rx_err;
  logic [7:0] rx_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .Clk      (Clk),
    .Reset    (Reset),
    .Rxd      (Rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err)
  );

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wadr_q, wadr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_COUNT;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      wadr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      we_q       <= we_d;
      wadr_q     <= wadr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    we_d       = 1'b0;
    wadr_d     = wadr_q;
    wdata_d    = wdata_q;
    // Done follows S_DONE by a cycle, so it rises the Clk after the final ImWe.
    done_d     = done_q | (state_q == S_DONE);
    err_d      = err_q;
    if (rx_err) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        S_COUNT: begin
          if (rx_valid) begin
            n_d        = (rx_data == 8'h00) ? FULL_CNT : (ADDR_W + 1)'(rx_data);
            byte_cnt_d = '0;
            word_cnt_d = '0;
            state_d    = S_LOAD;
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            word_d     = {word_q[23:0], rx_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              we_d       = 1'b1;
              wdata_d    = word_d;
              wadr_d     = word_cnt_q[ADDR_W-1:0];
              word_cnt_d = word_cnt_q + ONE_CNT;
              if (word_cnt_d == n_q) state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ImWe    = we_q;
  assign ImWAdr  = wadr_q;
  assign ImWData = wdata_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign CpuHold = ~done_q;

endmodule
